// File: rtl/cntry_req_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cntry_req_gen: country-road loop conditioning, vehicle queue, X request |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module cntry_req_gen #(
  parameter int DEB_CYCLES       = 4,
  parameter int DISCHARGE_CYCLES = 3,
  parameter int GAP_CYCLES       = 8
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       loop_raw,
  input  logic [1:0] cntry,
  output logic       X,
  output logic       det_pulse,
  output logic [3:0] car_count,
  output logic       ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_SERVE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [3:0] c_deb_last = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] c_dis_last = 4'(DISCHARGE_CYCLES - 1);
  localparam logic [3:0] c_gap_load = 4'(GAP_CYCLES);
  localparam logic [1:0] c_green    = 2'd2;
  localparam logic [3:0] c_max      = 4'd15;

  logic       r_meta;
  logic       r_sync;
  logic [3:0] r_deb_cnt;
  logic       r_filt;
  logic       r_filt_d;
  logic       r_det;
  logic [3:0] r_dis_cnt;
  logic [3:0] r_count;
  logic       r_ovf;
  logic [3:0] r_gap;
  logic       r_x;
  state_t     r_state;

  logic       w_rise;
  logic       w_green;
  logic       w_nonzero;
  logic       w_dis;
  logic [3:0] w_dis_nxt;
  logic [3:0] w_count_nxt;
  logic       w_ovf_set;
  state_t     w_state_nxt;
  logic [3:0] w_gap_nxt;

  assign w_rise    = r_filt & ~r_filt_d;
  assign w_green   = (cntry == c_green);
  assign w_nonzero = (r_count != 4'd0);

  // Two-flop synchroniser followed by the debounce filter.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_meta    <= 1'b0;
      r_sync    <= 1'b0;
      r_deb_cnt <= 4'd0;
      r_filt    <= 1'b0;
      r_filt_d  <= 1'b0;
      r_det     <= 1'b0;
    end else begin
      r_meta   <= loop_raw;
      r_sync   <= r_meta;
      r_filt_d <= r_filt;
      r_det    <= w_rise;
      if (r_sync == r_filt) begin
        r_deb_cnt <= 4'd0;
      end else if (r_deb_cnt == c_deb_last) begin
        r_filt    <= r_sync;
        r_deb_cnt <= 4'd0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_dis     = 1'b0;
    w_dis_nxt = 4'd0;
    if (w_green && w_nonzero) begin
      if (r_dis_cnt == c_dis_last) begin
        w_dis = 1'b1;
      end else begin
        w_dis_nxt = r_dis_cnt + 4'd1;
      end
    end
  end

  // A simultaneous arrival and discharge cancel each other out.
  always_comb begin
    w_count_nxt = r_count;
    w_ovf_set   = 1'b0;
    if (w_rise && !w_dis) begin
      if (r_count == c_max) begin
        w_ovf_set = 1'b1;
      end else begin
        w_count_nxt = r_count + 4'd1;
      end
    end else if (w_dis && !w_rise) begin
      w_count_nxt = r_count - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_dis_cnt <= 4'd0;
      r_count   <= 4'd0;
      r_ovf     <= 1'b0;
    end else begin
      r_dis_cnt <= w_dis_nxt;
      r_count   <= w_count_nxt;
      r_ovf     <= r_ovf | w_ovf_set;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (w_nonzero) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_green) begin
          w_state_nxt = S_SERVE;
        end
      end
      S_SERVE: begin
        if (!w_nonzero) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = c_gap_load;
        end else if (!w_green) begin
          w_state_nxt = S_REQ;
        end
      end
      S_GAP: begin
        w_gap_nxt = (r_gap != 4'd0) ? (r_gap - 4'd1) : 4'd0;
        // A fresh arrival outranks gap expiry in the same cycle.
        if (w_rise) begin
          w_state_nxt = S_SERVE;
        end else if (!w_green) begin
          w_state_nxt = w_nonzero ? S_REQ : S_IDLE;
        end else if (r_gap <= 4'd1) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_gap   <= 4'd0;
      r_x     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_x     <= (w_state_nxt != S_IDLE);
    end
  end

  assign X         = r_x;
  assign det_pulse = r_det;
  assign car_count = r_count;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cntry_req_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_cntry_req_gen: directed self-checking bench for cntry_req_gen       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_cntry_req_gen;

  logic       clock;
  logic       clear;
  logic       loop_raw;
  logic [1:0] cntry;
  logic       X;
  logic       det_pulse;
  logic [3:0] car_count;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  cntry_req_gen #(
    .DEB_CYCLES      (4),
    .DISCHARGE_CYCLES(3),
    .GAP_CYCLES      (8)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .loop_raw (loop_raw),
    .cntry    (cntry),
    .X        (X),
    .det_pulse(det_pulse),
    .car_count(car_count),
    .ovf      (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One vehicle: loop high for 10 edges then low long enough to settle.
  task automatic arrive();
    loop_raw = 1'b1;
    repeat (10) tick();
    loop_raw = 1'b0;
    repeat (8) tick();
  endtask

  // Same as arrive(), checking det/count/X latency edge by edge.
  task automatic arrive_checked(input string tag, input logic [3:0] base, input logic x_before);
    loop_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("%s_det_e%0d", tag, i), 8'(det_pulse), 8'(i == 6));
      check($sformatf("%s_cnt_e%0d", tag, i), 8'(car_count), (i >= 6) ? 8'(base + 4'd1) : 8'(base));
      check($sformatf("%s_x_e%0d", tag, i), 8'(X), (i >= 7) ? 8'd1 : 8'(x_before));
    end
    loop_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("%s_tail_det%0d", tag, i), 8'(det_pulse), 8'd0);
      check($sformatf("%s_tail_x%0d", tag, i), 8'(X), 8'd1);
    end
  endtask

  initial begin
    clear    = 1'b0;
    loop_raw = 1'b0;
    cntry    = 2'd0;
    repeat (3) tick();
    check("rst_x", 8'(X), 8'd0);
    check("rst_det", 8'(det_pulse), 8'd0);
    check("rst_cnt", 8'(car_count), 8'd0);
    check("rst_ovf", 8'(ovf), 8'd0);
    clear = 1'b1;
    tick();

    // Glitch of three cycles must be rejected.
    loop_raw = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) loop_raw = 1'b0;
      tick();
      check($sformatf("glitch_det%0d", i), 8'(det_pulse), 8'd0);
      check($sformatf("glitch_cnt%0d", i), 8'(car_count), 8'd0);
      check($sformatf("glitch_x%0d", i), 8'(X), 8'd0);
    end

    // First arrival, country RED.
    arrive_checked("arr1", 4'd0, 1'b0);

    // Second arrival, then discharge on GREEN and gap expiry.
    arrive();
    check("q2_cnt", 8'(car_count), 8'd2);
    cntry = 2'd2;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t == 2) check("dis_cnt_t2", 8'(car_count), 8'd2);
      if (t == 3) check("dis_cnt_t3", 8'(car_count), 8'd1);
      if (t == 5) check("dis_cnt_t5", 8'(car_count), 8'd1);
      if (t == 6) check("dis_cnt_t6", 8'(car_count), 8'd0);
      if (t >= 6) check($sformatf("gap_x_t%0d", t), 8'(X), (t < 15) ? 8'd1 : 8'd0);
    end
    check("gap_state_idle", 8'(dut.r_state), 8'd0);

    // Arrival landing on the gap-expiry cycle keeps the request alive.
    cntry = 2'd0;
    arrive();
    check("t4_cnt", 8'(car_count), 8'd1);
    cntry = 2'd2;
    for (int t = 1; t <= 24; t++) begin
      if (t == 6) loop_raw = 1'b1;
      if (t == 16) loop_raw = 1'b0;
      tick();
      if (t == 4)  check("t4_gap_entry", 8'(dut.r_state), 8'd3);
      if (t == 11) check("t4_gap_x", 8'(X), 8'd1);
      if (t == 12) begin
        check("t4_coinc_x", 8'(X), 8'd1);
        check("t4_coinc_state", 8'(dut.r_state), 8'd2);
        check("t4_coinc_cnt", 8'(car_count), 8'd1);
        check("t4_coinc_det", 8'(det_pulse), 8'd1);
      end
      if (t == 15) check("t4_redis_cnt", 8'(car_count), 8'd0);
      if (t >= 16) check($sformatf("t4_gap2_x%0d", t), 8'(X), (t < 24) ? 8'd1 : 8'd0);
    end

    // Saturation and sticky overflow.
    cntry = 2'd0;
    for (int i = 1; i <= 17; i++) begin
      arrive();
      check($sformatf("sat_cnt%0d", i), 8'(car_count), (i < 15) ? 8'(i) : 8'd15);
      check($sformatf("sat_ovf%0d", i), 8'(ovf), (i >= 16) ? 8'd1 : 8'd0);
    end

    // Discharge from 15; an arrival cancels the discharge that would take 5 to 4.
    cntry = 2'd2;
    for (int t = 1; t <= 36; t++) begin
      if (t == 27) loop_raw = 1'b1;
      if (t == 34) loop_raw = 1'b0;
      tick();
      if (t == 3)  check("mix_cnt_t3", 8'(car_count), 8'd14);
      if (t == 29) check("mix_cnt_t29", 8'(car_count), 8'd6);
      if (t == 30) check("mix_cnt_t30", 8'(car_count), 8'd5);
      if (t == 33) begin
        check("mix_cnt_t33", 8'(car_count), 8'd5);
        check("mix_det_t33", 8'(det_pulse), 8'd1);
      end
      if (t == 36) check("mix_cnt_t36", 8'(car_count), 8'd4);
    end
    check("mix_ovf", 8'(ovf), 8'd1);
    check("mix_x", 8'(X), 8'd1);
    check("mix_state_serve", 8'(dut.r_state), 8'd2);

    // Asynchronous clear in mid-cycle.
    #2;
    clear = 1'b0;
    #1;
    check("aclr_x", 8'(X), 8'd0);
    check("aclr_cnt", 8'(car_count), 8'd0);
    check("aclr_ovf", 8'(ovf), 8'd0);
    check("aclr_det", 8'(det_pulse), 8'd0);
    tick();
    tick();
    check("aclr_hold_x", 8'(X), 8'd0);
    check("aclr_hold_cnt", 8'(car_count), 8'd0);
    cntry = 2'd0;
    clear = 1'b1;
    tick();
    arrive_checked("post", 4'd0, 1'b0);
    check("post_ovf", 8'(ovf), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cntry_req_gen.md
Name: cntry_req_gen

Overview:
- Upstream stage of the highway/country signal controller; generates its country-road request input X.
- Conditions the raw country-road loop-detector signal: synchronise, debounce, arrival-edge detect.
- Keeps a saturating count of waiting vehicles and discharges them while the country light is GREEN.
- Holds X high until the queue is empty and a gap timeout has elapsed.

Parameters:
DEB_CYCLES, 4, consecutive cycles the synchronised input must differ from the filtered level before the filtered level flips (range 1..15)
DISCHARGE_CYCLES, 3, cycles per vehicle served while country is GREEN (range 1..15)
GAP_CYCLES, 8, cycles X stays high after the queue empties with no new arrival (range 1..15)

Ports:
clock  in  1  single system clock, rising edge
clear  in  1  asynchronous, active-low reset
loop_raw  in  1  raw loop detector, asynchronous to clock, 1 = vehicle over loop
cntry  in  2  country light state from controller: 0 RED, 1 YELLOW, 2 GREEN
X  out  1  country request to controller
det_pulse  out  1  one-cycle pulse per debounced vehicle arrival
car_count  out  4  vehicles waiting, saturating 0..15
ovf  out  1  sticky: arrival lost at car_count = 15

Behaviour:
- Reset (clear = 0, asynchronous) forces the following, all held while clear = 0:
  - X = 0, det_pulse = 0, car_count = 0, ovf = 0.
  - Synchroniser flops = 0, filtered level = 0, all timers = 0, FSM = IDLE.
- Synchroniser: two flops on loop_raw. Only the second flop (sync) is used downstream.
- Debounce:
  - Counter increments each cycle sync != filtered; resets to 0 whenever sync == filtered.
  - When the counter reaches DEB_CYCLES, filtered <= sync and the counter clears.
  - A glitch shorter than DEB_CYCLES never changes filtered.
- Arrival:
  - filtered 0->1 gives det_pulse = 1 for exactly the next cycle.
  - car_count increments on the same edge that asserts det_pulse.
  - Latency: loop_raw high before edge 0 gives det_pulse = 1 after edge 2+DEB_CYCLES. DEB_CYCLES = 4 means after edge 6.
- Discharge: runs only while cntry == 2 and car_count > 0.
  - The discharge timer counts to DISCHARGE_CYCLES, then decrements car_count by 1 and restarts.
  - The timer clears whenever cntry != 2 or car_count == 0.
- Count arithmetic:
  - Arrival and discharge in the same cycle leave car_count unchanged.
  - Arrival at 15 with no discharge: count stays 15 and ovf <= 1. ovf clears only on reset.
  - Never decrement below 0.
- FSM (X is registered, 1 in every state except IDLE):
  - IDLE: X = 0. car_count != 0 -> REQ. X rises on the edge after car_count first becomes nonzero.
  - REQ: cntry == 2 -> SERVE.
  - SERVE: car_count reaches 0 -> GAP, load gap timer with GAP_CYCLES. cntry != 2 with car_count > 0 -> REQ.
  - GAP: gap timer decrements each cycle.
    - Arrival -> SERVE (arrival has priority over expiry in the same cycle).
    - Timer reaches 0 -> IDLE; X falls on that edge.
    - cntry != 2 -> IDLE if car_count == 0, else REQ.
  - Illegal encoding -> IDLE.
- Reset mid-operation: immediate return to reset values. The next arrival requires a full debounce from filtered = 0.

Test Plan:
1. Reset, then loop_raw high 3 cycles then low, DEB_CYCLES = 4 -> no det_pulse, car_count = 0, X = 0 throughout.
2. loop_raw high 10 cycles from edge 0, cntry = 0 -> det_pulse only in the cycle after edge 6, car_count = 1 after edge 6, X = 1 after edge 7, X stays 1.
3. car_count = 2, then cntry = 2 -> car_count 1 after 3 cycles, 0 after 6 cycles; X stays 1 for 8 more cycles, then 0; FSM IDLE.
4. Arrival in GAP on the same cycle the timer expires -> X stays 1, FSM SERVE, car_count = 1.
5. 16 arrivals with cntry = 0 -> car_count = 15, ovf = 1; a further arrival leaves both unchanged. Arrival coinciding with a discharge at count 5 -> count stays 5.
6. clear pulsed low mid-SERVE with car_count = 4 -> X, car_count, ovf, det_pulse = 0 immediately, without waiting for a clock edge; normal operation after release.
